jedro_1_decoder: RTL and testbench

- Decode stage of the riscv-jedro-1 core. It sits between fetch and the ALU and is the producer side of the ALU interface.
- Accepts one 32-bit instruction per valid/ready handshake and reads two register-file ports.
- Generates the ALU operation select and both operands, plus writeback info, into one registered output stage with valid/ready.
- Supports RV32I OP, OP-IMM, LUI and AUIPC. Everything else traps.

---
 rtl/jedro_1_decoder.sv | 180 ++++++++++++++++++
 tb/tb_jedro_1_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_decoder.sv
// jedro_1 decode stage: RV32I OP/OP-IMM/LUI/AUIPC into ALU op and operands.
// Ports: fetch in (instr/pc valid/ready), RF reads, registered ALU beat out.
module jedro_1_decoder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [31:0]             instr_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [4:0]              rf_addr_a_o,
  output logic [4:0]              rf_addr_b_o,
  input  logic [DATA_WIDTH-1:0]   rf_data_a_i,
  input  logic [DATA_WIDTH-1:0]   rf_data_b_i,
  output logic [ALU_OP_WIDTH-1:0] alu_op_sel_o,
  output logic [DATA_WIDTH-1:0]   opa_o,
  output logic [DATA_WIDTH-1:0]   opb_o,
  output logic [4:0]              rd_addr_o,
  output logic                    rd_we_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    illegal_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  typedef enum logic {
    RUN,
    TRAP
  } state_t;

  state_t state_q, state_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       is_op, is_opi, is_lui, is_auipc;

  logic [DATA_WIDTH-1:0] rs1_d, rs2_d;
  logic [DATA_WIDTH-1:0] imm_i, imm_u, shamt;

  logic                  d_ill;
  logic [3:0]            d_op;
  logic [DATA_WIDTH-1:0] d_opa, d_opb;

  logic accept;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign rd  = instr_i[11:7];

  assign rf_addr_a_o = instr_i[19:15];
  assign rf_addr_b_o = instr_i[24:20];

  // x0 reads as zero whatever the register file returns
  assign rs1_d = (rf_addr_a_o == 5'd0) ? '0 : rf_data_a_i;
  assign rs2_d = (rf_addr_b_o == 5'd0) ? '0 : rf_data_b_i;

  assign imm_i = DATA_WIDTH'($signed(instr_i[31:20]));
  assign imm_u = DATA_WIDTH'({instr_i[31:12], 12'b0});
  assign shamt = DATA_WIDTH'(instr_i[24:20]);

  // full 7-bit match also enforces instr[1:0] == 2'b11
  assign is_op    = (opc == OPC_OP);
  assign is_opi   = (opc == OPC_OPIMM);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);

  always_comb begin
    d_ill = 1'b1;
    d_op  = ALU_ADD;
    d_opa = '0;
    d_opb = '0;
    unique case (1'b1)
      is_op: begin
        d_opa = rs1_d;
        d_opb = rs2_d;
        d_op  = {instr_i[30], f3};
        if (f7 == F7_ZERO)
          d_ill = 1'b0;
        else if (f7 == F7_ALT &&
                 (f3 == 3'b000 || f3 == 3'b101))
          d_ill = 1'b0;
      end
      is_opi: begin
        d_opa = rs1_d;
        if (f3 == 3'b001) begin
          d_op  = ALU_SLL;
          d_opb = shamt;
          d_ill = (f7 != F7_ZERO);
        end else if (f3 == 3'b101) begin
          d_opb = shamt;
          if (f7 == F7_ZERO) begin
            d_op  = ALU_SRL;
            d_ill = 1'b0;
          end else if (f7 == F7_ALT) begin
            d_op  = ALU_SRA;
            d_ill = 1'b0;
          end
        end else begin
          d_op  = {1'b0, f3};
          d_opb = imm_i;
          d_ill = 1'b0;
        end
      end
      is_lui: begin
        d_opb = imm_u;
        d_ill = 1'b0;
      end
      is_auipc: begin
        d_opa = pc_i;
        d_opb = imm_u;
        d_ill = 1'b0;
      end
      default: ;
    endcase
    // illegal beats carry a neutral ADD 0,0
    if (d_ill) begin
      d_op  = ALU_ADD;
      d_opa = '0;
      d_opb = '0;
    end
  end

  assign in_ready_o = (state_q == RUN) &&
                      (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && accept && d_ill)
      state_d = TRAP;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      alu_op_sel_o <= '0;
      opa_o        <= '0;
      opb_o        <= '0;
      rd_addr_o    <= '0;
      rd_we_o      <= 1'b0;
      out_valid_o  <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (accept) begin
      alu_op_sel_o <= ALU_OP_WIDTH'(d_op);
      opa_o        <= d_opa;
      opb_o        <= d_opb;
      rd_addr_o    <= rd;
      rd_we_o      <= !d_ill && (rd != 5'd0);
      out_valid_o  <= 1'b1;
      illegal_o    <= d_ill;
    end else if (out_ready_i) begin
      // illegal_o is left set: it is the sticky trap flag
      out_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Bench for jedro_1_decoder: scoreboard of expected ALU beats.
// Covers decode table, x0 forcing, backpressure, trap and async reset.
module tb_jedro_1_decoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  ra, rb;
  logic [31:0] rfa = '0, rfb = '0;
  logic [3:0]  op;
  logic [31:0] opa, opb;
  logic [4:0]  rd;
  logic        we;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ill;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int pushed = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  jedro_1_decoder dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .instr_i      (instr),
    .pc_i         (pc),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .rf_addr_a_o  (ra),
    .rf_addr_b_o  (rb),
    .rf_data_a_i  (rfa),
    .rf_data_b_i  (rfb),
    .alu_op_sel_o (op),
    .opa_o        (opa),
    .opb_o        (opb),
    .rd_addr_o    (rd),
    .rd_we_o      (we),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .illegal_o    (ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] o,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input logic [4:0] r,
                              input logic w,
                              input logic i);
    exp_t e;
    e.op = o; e.opa = a; e.opb = b;
    e.rd = r; e.we = w; e.ill = i;
    return e;
  endfunction

  task automatic send(input logic [31:0] ins,
                      input logic [31:0] p,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input exp_t e);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    instr = ins; pc = p; rfa = a; rfb = b;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        check("rf_addr_a", 32'(ra), 32'(ins[19:15]));
        check("rf_addr_b", 32'(rb), 32'(ins[24:20]));
        sb.push_back(e);
        pushed++;
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // consume a beat at the negedge before the edge that drains it
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("op",  32'(op),  32'(e.op));
        check("opa", opa,      e.opa);
        check("opb", opb,      e.opb);
        check("rd",  32'(rd),  32'(e.rd));
        check("we",  32'(we),  32'(e.we));
        check("ill", 32'(ill), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ill",   32'(ill), 0);
    check("rst_opa",   opa, 0);
    check("rst_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;

    // ADD x3,x1,x2 with single-cycle latency
    send(32'h002081B3, 0, 5, 7,
         mk(4'b0000, 5, 7, 3, 1, 0));
    @(negedge clk);
    check("add_latency", 32'(out_valid), 1);

    // SRAI x5,x6,4
    send(32'h40435293, 0, 32'h80000000, 9,
         mk(4'b1101, 32'h80000000, 4, 5, 1, 0));
    // SUB x1,x0,x2: rs1 data ignored
    send(32'h402000B3, 0, 32'hFFFFFFFF, 3,
         mk(4'b1000, 0, 3, 1, 1, 0));
    // LUI x7,0x12345
    send(32'h123453B7, 0, 32'hDEAD, 32'hBEEF,
         mk(4'b0000, 0, 32'h12345000, 7, 1, 0));
    // AUIPC x1,1
    send(32'h00001097, 32'h100, 1, 2,
         mk(4'b0000, 32'h100, 32'h1000, 1, 1, 0));
    // ADDI x2,x1,-1
    send(32'hFFF08113, 0, 10, 0,
         mk(4'b0000, 10, 32'hFFFFFFFF, 2, 1, 0));
    // XOR x0,x1,x2: no write to x0
    send(32'h0020C033, 0, 1, 2,
         mk(4'b0100, 1, 2, 0, 0, 0));

    // backpressure: first beat held, second waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h002081B3, 0, 32'h11, 32'h22,
         mk(4'b0000, 32'h11, 32'h22, 3, 1, 0));
    fork
      send(32'h002081B3, 0, 32'h33, 32'h44,
           mk(4'b0000, 32'h33, 32'h44, 3, 1, 0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready", 32'(in_ready), 0);
          check("bp_hold", opa, 32'h11);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    check("bp_sb_empty", sb.size(), 0);

    // bad funct7 for SLT traps
    send(32'h4020A1B3, 0, 1, 2,
         mk(4'b0000, 0, 0, 3, 0, 1));
    repeat (2) @(negedge clk);
    check("f7_sticky", 32'(ill), 1);
    check("f7_valid",  32'(out_valid), 0);
    check("f7_ready",  32'(in_ready), 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    check("rst_clr_ill", 32'(ill), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // all-zero word is illegal
    send(32'h00000000, 0, 1, 2,
         mk(4'b0000, 0, 0, 0, 0, 1));
    @(posedge clk); #1;
    instr = 32'h002081B3;
    in_valid = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready) hi++;
    end
    check("trap_ready_cycles", hi, 0);
    check("trap_sticky", 32'(ill), 1);
    check("trap_valid",  32'(out_valid), 0);

    // async reset between edges
    #2;
    rstn = 1'b0;
    #1;
    check("amr_valid", 32'(out_valid), 0);
    check("amr_ill",   32'(ill), 0);
    check("amr_op",    32'(op), 0);
    check("amr_opb",   opb, 0);
    check("amr_we",    32'(we), 0);
    check("amr_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("beat_count", beats, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
